// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The field helpers keep the decode split in one place so the
// bit positions are never repeated by hand elsewhere.
package fetch_pkg;

    // Fetch sequencing: issue a request, wait for the reply, hold it for decode
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Instruction presented before anything real has been fetched (addi x0,x0,0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sequential fetch advances one 32-bit word
    localparam logic [31:0] PC_STEP = 32'd4;

    // Bit positions of the pre-split fields handed to decode
    localparam int OP_LSB     = 0;
    localparam int OP_MSB     = 6;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT7_BIT = 30;

    // Major opcode of an instruction word
    function automatic logic [6:0] instr_op(input logic [31:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

    // funct3 field of an instruction word
    function automatic logic [2:0] instr_funct3(input logic [31:0] word);
        return word[FUNCT3_MSB:FUNCT3_LSB];
    endfunction

    // The single funct7 bit that distinguishes add/sub and srl/sra
    function automatic logic instr_funct7(input logic [31:0] word);
        return word[FUNCT7_BIT];
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter for the fetch stage.
// A redirect load always beats the sequential increment, and the
// loaded address is forced onto a word boundary by construction:
// only the word-address bits of the target are ever presented here.
module pc_register
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            load,
    input  logic [XLEN-3:0] load_word,
    output logic [XLEN-1:0] pc
);

    // Reset to the boot address, otherwise redirect or step to the next word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= {load_word, 2'b00};
        end else if (inc) begin
            pc <= pc + PC_STEP[XLEN-1:0];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding control_unit.
// Keeps exactly one memory request in flight, parks the returned word
// in a holding register for decode, and honours a downstream redirect
// in any state. A redirect that lands while a request is still
// outstanding marks that reply as stale (kill) so it is thrown away
// when it finally arrives instead of reaching decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,

    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7,
    output logic [XLEN-1:0] instr_pc,

    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            misalign
);

    fetch_state_t    state;
    logic            kill;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            misalign_q;
    logic [XLEN-1:0] pc;
    logic            pc_inc;
    logic            pc_load;

    // A redirect always wins; decode consuming the held word only steps
    // the PC when no redirect arrives in the same cycle.
    assign pc_load = PCSrc;
    assign pc_inc  = (state == HOLD) && instr_ready && !PCSrc;

    pc_register #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC[XLEN-1:0])
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (pc_inc),
        .load      (pc_load),
        .load_word (PCTarget[XLEN-1:2]),
        .pc        (pc)
    );

    // Request sequencing, stale-reply tracking and the decode holding register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH;
            kill       <= 1'b0;
            instr_q    <= NOP_INSTR[XLEN-1:0];
            instr_pc_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= PCSrc && (PCTarget[1:0] != 2'b00);
            unique case (state)
                FETCH: begin
                    if (imem_ready) begin
                        state <= WAIT;
                        kill  <= PCSrc;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (!kill && !PCSrc) begin
                            instr_q    <= imem_rdata;
                            instr_pc_q <= pc;
                            state      <= HOLD;
                        end else begin
                            state <= FETCH;
                        end
                        kill <= 1'b0;
                    end else if (PCSrc) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (PCSrc || instr_ready) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                    kill  <= 1'b0;
                end
            endcase
        end
    end

    // The request is gated by reset so memory never sees one while the
    // stage is being held in reset, even though the state already reads FETCH.
    assign imem_req    = rst_n && (state == FETCH);
    assign imem_addr   = pc;

    assign instr_valid = (state == HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign op          = instr_op(instr_q);
    assign funct3      = instr_funct3(instr_q);
    assign funct7      = instr_funct7(instr_q);
    assign misalign    = misalign_q;

endmodule
